// File: rtl/lenet_pkg.sv
// Shared encodings and widths for the LeNet convolution scheduler.
// State encoding is one-hot so each state can be probed with a single bit.
package lenet_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_LOAD_W = 5'b00010,
        ST_CALC   = 5'b00100,
        ST_DRAIN  = 5'b01000,
        ST_DONE   = 5'b10000
    } state_t;

    localparam int DEF_PIPE_LAT = 7;

    localparam int W_ADDR_W   = 8;
    localparam int W_IDX_W    = 5;
    localparam int POS_W      = 5;
    localparam int OUT_ADDR_W = 10;
    localparam int MAP_W      = 3;
    localparam int CNT_W      = 6;

    // Delay-line payload: {valid, out_addr, out_map}
    localparam int PAYLOAD_W = 1 + OUT_ADDR_W + MAP_W;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-latency shift register; synchronous reset clears every stage so
// nothing in flight survives an abort.
module pipe_delay #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/conv2d_scheduler.sv
// Layer sequencer for a 5x5 convolution: per map it loads weights+bias,
// streams every output window, then drains the datapath before the next map.
module conv2d_scheduler
    import lenet_pkg::*;
#(
    parameter int OUT_W    = 28,
    parameter int OUT_H    = 28,
    parameter int N_MAP    = 6,
    parameter int W_DEPTH  = 26,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  w_rd_en,
    output logic [W_ADDR_W-1:0]   w_rd_addr,
    output logic                  w_wr_en,
    output logic [W_IDX_W-1:0]    w_wr_idx,
    output logic                  win_valid,
    output logic [POS_W-1:0]      win_row,
    output logic [POS_W-1:0]      win_col,
    output logic                  out_valid,
    output logic [OUT_ADDR_W-1:0] out_addr,
    output logic [MAP_W-1:0]      out_map
);

    // Handshake: every strobe here is a single-cycle qualifier; there is no
    // back-pressure, so a strobe high in a cycle means the paired fields are
    // valid in that same cycle and are consumed unconditionally.

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt;
    logic                  calc_first;
    logic [POS_W-1:0]      row;
    logic [POS_W-1:0]      col;
    logic [MAP_W-1:0]      map;
    logic [W_IDX_W-1:0]    k;
    logic                  last_win;
    logic [PAYLOAD_W-1:0]  pipe_in;
    logic [PAYLOAD_W-1:0]  pipe_out;

    // LOAD_W spends its first cycle with cnt=0 (no read), then reads k=cnt-1.
    always_comb begin
        k         = W_IDX_W'(cnt - CNT_W'(1));
        w_rd_en   = (state == ST_LOAD_W) && (cnt != '0);
        w_rd_addr = '0;
        if (w_rd_en) begin
            w_rd_addr = W_ADDR_W'(map) * W_ADDR_W'(W_DEPTH) + W_ADDR_W'(k);
        end
        win_valid = (state == ST_CALC) && !calc_first;
        last_win  = (row == POS_W'(OUT_H - 1)) && (col == POS_W'(OUT_W - 1));
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        win_row   = row;
        win_col   = col;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start) state_next = ST_LOAD_W;
            end
            ST_LOAD_W: begin
                if (cnt == CNT_W'(W_DEPTH)) state_next = ST_CALC;
            end
            ST_CALC: begin
                if (win_valid && last_win) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cnt == CNT_W'(PIPE_LAT - 1)) begin
                    if (map == MAP_W'(N_MAP - 1)) state_next = ST_DONE;
                    else                          state_next = ST_LOAD_W;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            calc_first <= 1'b0;
            row        <= '0;
            col        <= '0;
            map        <= '0;
            w_wr_en    <= 1'b0;
            w_wr_idx   <= '0;
        end else begin
            state      <= state_next;
            calc_first <= (state != ST_CALC) && (state_next == ST_CALC);

            if (state_next != state) begin
                cnt <= '0;
            end else if (state == ST_LOAD_W || state == ST_DRAIN) begin
                cnt <= cnt + CNT_W'(1);
            end

            // Column is the inner loop; the last window wraps both to zero.
            if (win_valid) begin
                if (col == POS_W'(OUT_W - 1)) begin
                    col <= '0;
                    row <= last_win ? '0 : row + POS_W'(1);
                end else begin
                    col <= col + POS_W'(1);
                end
            end else if (state == ST_IDLE) begin
                row <= '0;
                col <= '0;
            end

            if (state == ST_DRAIN && state_next == ST_LOAD_W) begin
                map <= map + MAP_W'(1);
            end else if (state_next == ST_IDLE) begin
                map <= '0;
            end

            // Synchronous ROM: data arrives one cycle after the read strobe.
            w_wr_en  <= w_rd_en;
            w_wr_idx <= w_rd_en ? k : '0;
        end
    end

    always_comb begin
        pipe_in = '0;
        if (win_valid) begin
            pipe_in = {1'b1,
                       OUT_ADDR_W'(row) * OUT_ADDR_W'(OUT_W) + OUT_ADDR_W'(col),
                       map};
        end
    end

    pipe_delay #(
        .WIDTH (PAYLOAD_W),
        .DEPTH (PIPE_LAT)
    ) u_pipe_delay (
        .clk (clk),
        .rst (rst),
        .d   (pipe_in),
        .q   (pipe_out)
    );

    assign out_valid = pipe_out[PAYLOAD_W-1];
    assign out_addr  = pipe_out[MAP_W +: OUT_ADDR_W];
    assign out_map   = pipe_out[MAP_W-1:0];

endmodule

// File: tb/tb_conv2d_scheduler.sv
// Scoreboard bench: a per-layer reference schedule is queued at start and a
// negedge monitor retires every strobe the scheduler presents against it.
module tb_conv2d_scheduler;

    localparam int OW = 28;
    localparam int OH = 28;
    localparam int NM = 6;
    localparam int WD = 26;
    localparam int PL = 7;
    localparam int SW = 2;
    localparam int SH = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic       start_b;

    logic       busy, done, w_rd_en, w_wr_en, win_valid, out_valid;
    logic [7:0] w_rd_addr;
    logic [4:0] w_wr_idx, win_row, win_col;
    logic [9:0] out_addr;
    logic [2:0] out_map;

    logic       busy_b, done_b, w_rd_en_b, w_wr_en_b, win_valid_b, out_valid_b;
    logic [7:0] w_rd_addr_b;
    logic [4:0] w_wr_idx_b, win_row_b, win_col_b;
    logic [9:0] out_addr_b;
    logic [2:0] out_map_b;

    conv2d_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_wr_en(w_wr_en),
        .w_wr_idx(w_wr_idx), .win_valid(win_valid), .win_row(win_row),
        .win_col(win_col), .out_valid(out_valid), .out_addr(out_addr),
        .out_map(out_map)
    );

    conv2d_scheduler #(.OUT_W(SW), .OUT_H(SH), .N_MAP(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .w_rd_en(w_rd_en_b), .w_rd_addr(w_rd_addr_b), .w_wr_en(w_wr_en_b),
        .w_wr_idx(w_wr_idx_b), .win_valid(win_valid_b), .win_row(win_row_b),
        .win_col(win_col_b), .out_valid(out_valid_b), .out_addr(out_addr_b),
        .out_map(out_map_b)
    );

    // ---------------- clock / reset / cycle count ----------------
    int cyc;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [44:0] exp_q[$];    // {cycle, map, addr}
    logic [39:0] rd_q[$];     // {cycle, rom addr}
    logic [36:0] wr_q[$];     // {cycle, reg idx}
    int          done_q[$];
    logic [44:0] exp_b_q[$];
    int          done_b_q[$];
    int          busy_from, busy_to, busy_from_b, busy_to_b;
    int          n_tests, n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_bad(input string name, input logic [63:0] val);
        n_tests++;
        n_fail++;
        $display("FAIL %s: item %0h (cycle %0d)", name, val, cyc);
    endtask

    // Reference schedule: per map one setup cycle, W_DEPTH reads, one quiet
    // CALC cycle, ow*oh windows, PIPE_LAT drain; done follows the last map.
    task automatic model_run(input int sel, input int t0);
        int ow, oh, nm, per, base, slot;
        ow  = sel ? SW : OW;
        oh  = sel ? SH : OH;
        nm  = sel ? 1 : NM;
        per = 1 + WD + 1 + ow * oh + PL;
        for (int m = 0; m < nm; m++) begin
            base = t0 + 1 + m * per;
            if (sel == 0) begin
                for (int k = 0; k < WD; k++) begin
                    rd_q.push_back({32'(base + 1 + k), 8'(m * WD + k)});
                    wr_q.push_back({32'(base + 2 + k), 5'(k)});
                end
            end
            slot = 0;
            for (int r = 0; r < oh; r++) begin
                for (int c = 0; c < ow; c++) begin
                    if (sel == 0)
                        exp_q.push_back({32'(base + WD + 2 + slot + PL), 3'(m), 10'(r * ow + c)});
                    else
                        exp_b_q.push_back({32'(base + WD + 2 + slot + PL), 3'(m), 10'(r * ow + c)});
                    slot++;
                end
            end
        end
        if (sel == 0) begin
            done_q.push_back(t0 + 1 + nm * per);
            busy_from = t0 + 1;
            busy_to   = t0 + 1 + nm * per;
        end else begin
            done_b_q.push_back(t0 + 1 + nm * per);
            busy_from_b = t0 + 1;
            busy_to_b   = t0 + 1 + nm * per;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        while (exp_q.size() > 0 && int'(exp_q[0][44:13]) < cyc) note_bad("out_missing", exp_q.pop_front());
        while (rd_q.size() > 0 && int'(rd_q[0][39:8]) < cyc) note_bad("rd_missing", rd_q.pop_front());
        while (wr_q.size() > 0 && int'(wr_q[0][36:5]) < cyc) note_bad("wr_missing", wr_q.pop_front());
        while (done_q.size() > 0 && done_q[0] < cyc) note_bad("done_missing", done_q.pop_front());
        while (exp_b_q.size() > 0 && int'(exp_b_q[0][44:13]) < cyc) note_bad("b_out_missing", exp_b_q.pop_front());
        while (done_b_q.size() > 0 && done_b_q[0] < cyc) note_bad("b_done_missing", done_b_q.pop_front());

        if (out_valid) begin
            if (exp_q.size() == 0) note_bad("out_extra", {cyc, out_map, out_addr});
            else check("out", {cyc, out_map, out_addr}, exp_q.pop_front());
        end
        if (w_rd_en) begin
            if (rd_q.size() == 0) note_bad("rd_extra", {cyc, w_rd_addr});
            else check("rd", {cyc, w_rd_addr}, rd_q.pop_front());
        end
        if (w_wr_en) begin
            if (wr_q.size() == 0) note_bad("wr_extra", {cyc, w_wr_idx});
            else check("wr", {cyc, w_wr_idx}, wr_q.pop_front());
        end
        if (done) begin
            if (done_q.size() == 0) note_bad("done_extra", cyc);
            else check("done_cycle", cyc, done_q.pop_front());
        end
        check("busy", busy, (cyc >= busy_from && cyc <= busy_to));

        if (out_valid_b) begin
            if (exp_b_q.size() == 0) note_bad("b_out_extra", {cyc, out_map_b, out_addr_b});
            else check("b_out", {cyc, out_map_b, out_addr_b}, exp_b_q.pop_front());
        end
        if (done_b) begin
            if (done_b_q.size() == 0) note_bad("b_done_extra", cyc);
            else check("b_done_cycle", cyc, done_b_q.pop_front());
        end
        check("b_busy", busy_b, (cyc >= busy_from_b && cyc <= busy_to_b));
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycle(input int c);
        while (cyc < c) step();
    endtask

    task automatic pulse_start(input int sel, input bit modelled);
        if (modelled) model_run(sel, cyc);
        if (sel == 0) start = 1'b1;
        else          start_b = 1'b1;
        step();
        start   = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((done_q.size() > 0 || done_b_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) note_bad("done_timeout", budget);
        repeat ($urandom_range(1, 4)) step();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {busy, done, w_rd_en, w_wr_en, win_valid, out_valid}, '0);
        check({tag, "_data"}, {w_rd_addr, w_wr_idx, win_row, win_col, out_addr, out_map}, '0);
        check({tag, "_b"}, {busy_b, done_b, w_rd_en_b, w_wr_en_b, win_valid_b, out_valid_b,
                            w_rd_addr_b, w_wr_idx_b, win_row_b, win_col_b, out_addr_b, out_map_b}, '0);
    endtask

    task automatic flush_model();
        exp_q.delete();
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        exp_b_q.delete();
        done_b_q.delete();
        busy_from = 1; busy_to = 0;
        busy_from_b = 1; busy_to_b = 0;
    endtask

    // ---------------- main sequence ----------------
    localparam int PER = 1 + WD + 1 + OW * OH + PL;

    initial begin
        int t0, m, off;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        start   = 1'b0;
        start_b = 1'b0;
        rst     = 1'b1;
        flush_model();
        repeat (3) step();
        rst = 1'b0;
        check_quiet("reset");

        // Plain full layer
        repeat ($urandom_range(0, 5)) step();
        pulse_start(0, 1'b1);
        wait_done(NM * PER + 50);

        // Start pulsed in the middle of CALC must be ignored
        repeat ($urandom_range(0, 5)) step();
        t0 = cyc;
        pulse_start(0, 1'b1);
        m   = $urandom_range(0, NM - 1);
        off = $urandom_range(0, OW * OH - 1);
        wait_cycle(t0 + 1 + m * PER + WD + 2 + off);
        pulse_start(0, 1'b0);
        wait_done(NM * PER + 50);

        // Reset during DRAIN aborts everything including in-flight results
        t0 = cyc;
        pulse_start(0, 1'b1);
        m   = $urandom_range(0, NM - 1);
        off = $urandom_range(0, PL - 1);
        wait_cycle(t0 + 1 + m * PER + WD + 2 + OW * OH + off);
        rst = 1'b1;
        step();
        rst = 1'b0;
        flush_model();
        check_quiet("mid_rst");
        repeat ($urandom_range(1, 5)) step();
        pulse_start(0, 1'b1);
        wait_done(NM * PER + 50);

        // Small instance: four results in address order, then done
        pulse_start(1, 1'b1);
        wait_done(200);

        check("queues_empty", exp_q.size() + rd_q.size() + wr_q.size() + done_q.size()
                              + exp_b_q.size() + done_b_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
